// File: rtl/crc32_pkg.sv
// crc32_pkg: shared CRC-32/ISO-HDLC constants, FSM state type and byte-step function
package crc32_pkg;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOR_OUT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Reflected-input engine shifts right, so it uses the bit-reversed polynomial.
  localparam logic [31:0] CRC_POLY_REF = reflect32(CRC_POLY);

  function automatic logic [31:0] crc32_d8(input logic [7:0] data, input logic [31:0] crc);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REF) : (c >> 1);
    return c;
  endfunction
endpackage

// File: rtl/crc32_word_step.sv
// crc32_word_step: folds 1..4 bytes of a word (byte0 first) into a CRC in one cycle
module crc32_word_step
  import crc32_pkg::*;
(
  input  logic [31:0] data,
  input  logic [31:0] crc_in,
  input  logic [1:0]  nbytes_m1,
  output logic [31:0] crc_out
);
  logic [31:0] c [5];

  assign c[0] = crc_in;
  for (genvar g = 0; g < 4; g++) begin : g_stage
    assign c[g+1] = crc32_d8(data[8*g +: 8], c[g]);
  end
  assign crc_out = c[{1'b0, nbytes_m1} + 3'd1];
endmodule

// File: rtl/crc32_frame_arb.sv
// crc32_frame_arb: two-source round-robin frame arbiter feeding a CRC-32 engine
module crc32_frame_arb
  import crc32_pkg::*;
#(
  parameter logic [31:0] INIT    = CRC_INIT,
  parameter logic [31:0] XOR_OUT = CRC_XOR_OUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s0_data,
  input  logic        s0_valid,
  input  logic        s0_sop,
  input  logic        s0_eop,
  input  logic [1:0]  s0_keep,
  output logic        s0_ready,
  input  logic [31:0] s1_data,
  input  logic        s1_valid,
  input  logic        s1_sop,
  input  logic        s1_eop,
  input  logic [1:0]  s1_keep,
  output logic        s1_ready,
  output logic        crc_valid,
  input  logic        crc_ready,
  output logic [31:0] crc_out,
  output logic        crc_src,
  output logic        crc_err,
  output logic [15:0] drop_cnt
);
  state_t      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, first_q, first_d, err_q, err_d;
  logic [31:0] crc_q, crc_d, crc_out_q, crc_out_d;
  logic        crc_valid_q, crc_valid_d, crc_src_q, crc_src_d, crc_err_q, crc_err_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        req0, req1, orph0, orph1, w_valid, w_sop, w_eop, acc, err_nx;
  logic [31:0] w_data, crc_base, crc_nx;
  logic [1:0]  w_keep;
  logic [16:0] drop_sum;

  assign req0     = s0_valid & s0_sop;
  assign req1     = s1_valid & s1_sop;
  assign orph0    = (state_q == IDLE) & s0_valid & ~s0_sop;
  assign orph1    = (state_q == IDLE) & s1_valid & ~s1_sop;
  assign w_data   = gnt_q ? s1_data : s0_data;
  assign w_valid  = gnt_q ? s1_valid : s0_valid;
  assign w_sop    = gnt_q ? s1_sop : s0_sop;
  assign w_eop    = gnt_q ? s1_eop : s0_eop;
  assign w_keep   = gnt_q ? s1_keep : s0_keep;
  assign acc      = (state_q == BUSY) & w_valid;
  // A sop on any accepted word (first or mid-frame) restarts the CRC from the seed.
  assign crc_base = (first_q | w_sop) ? INIT : crc_q;
  assign err_nx   = err_q | (w_sop & ~first_q);
  assign drop_sum = {1'b0, drop_cnt_q} + {16'd0, orph0} + {16'd0, orph1};
  // Orphan words need same-cycle ready, so ready is decoded from state and gated by reset.
  assign s0_ready = rst_n & (orph0 | ((state_q == BUSY) & ~gnt_q));
  assign s1_ready = rst_n & (orph1 | ((state_q == BUSY) & gnt_q));
  assign crc_valid = crc_valid_q;
  assign crc_out   = crc_out_q;
  assign crc_src   = crc_src_q;
  assign crc_err   = crc_err_q;
  assign drop_cnt  = drop_cnt_q;

  crc32_word_step u_step (
    .data      (w_data),
    .crc_in    (crc_base),
    .nbytes_m1 (w_eop ? w_keep : 2'd3),
    .crc_out   (crc_nx)
  );

  // Next-state: grant in IDLE, fold words in BUSY, hold the result until handshake.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    first_d     = first_q;
    err_d       = err_q;
    crc_d       = crc_q;
    crc_out_d   = crc_out_q;
    crc_valid_d = crc_valid_q;
    crc_src_d   = crc_src_q;
    crc_err_d   = crc_err_q;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      IDLE: begin
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (req0 | req1) begin
          state_d = BUSY;
          gnt_d   = (req0 & req1) ? rr_ptr_q : req1;
          first_d = 1'b1;
          err_d   = 1'b0;
        end
      end
      BUSY: if (acc) begin
        crc_d   = crc_nx;
        first_d = 1'b0;
        err_d   = err_nx;
        if (w_eop) begin
          state_d     = RESULT;
          crc_valid_d = 1'b1;
          crc_out_d   = crc_nx ^ XOR_OUT;
          crc_src_d   = gnt_q;
          crc_err_d   = err_nx;
        end
      end
      RESULT: if (crc_ready) begin
        state_d     = IDLE;
        crc_valid_d = 1'b0;
        rr_ptr_d    = ~crc_src_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and registered outputs, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      gnt_q       <= 1'b0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      crc_q       <= INIT;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
      crc_src_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      first_q     <= first_d;
      err_q       <= err_d;
      crc_q       <= crc_d;
      crc_out_q   <= crc_out_d;
      crc_valid_q <= crc_valid_d;
      crc_src_q   <= crc_src_d;
      crc_err_q   <= crc_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_crc32_frame_arb.sv
// tb_crc32_frame_arb: directed and randomized self-checking bench for crc32_frame_arb
module tb_crc32_frame_arb;
  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  keep;
  } word_t;

  logic        clk, rst_n;
  logic [31:0] s0_data, s1_data;
  logic        s0_valid, s0_sop, s0_eop, s0_ready;
  logic        s1_valid, s1_sop, s1_eop, s1_ready;
  logic [1:0]  s0_keep, s1_keep;
  logic        crc_valid, crc_ready, crc_src, crc_err;
  logic [31:0] crc_out;
  logic [15:0] drop_cnt;

  int          errors = 0;
  int          checks = 0;
  word_t       frame_q[$];
  logic [7:0]  bytes_q[$];
  logic [31:0] exp_crc, last_crc;
  logic        exp_err;

  crc32_frame_arb dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_sop(s0_sop), .s0_eop(s0_eop),
    .s0_keep(s0_keep), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_sop(s1_sop), .s1_eop(s1_eop),
    .s1_keep(s1_keep), .s1_ready(s1_ready),
    .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_out(crc_out),
    .crc_src(crc_src), .crc_err(crc_err), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic word_t mk(input logic [31:0] d, input logic sop, input logic eop,
                               input logic [1:0] keep);
    word_t w;
    w.d = d; w.sop = sop; w.eop = eop; w.keep = keep;
    return w;
  endfunction

  // Textbook MSB-first CRC-32 with explicit byte and result reflection.
  function automatic logic [31:0] ref_crc();
    logic [31:0] c, r;
    logic [7:0]  rb;
    c = 32'hFFFFFFFF;
    foreach (bytes_q[i]) begin
      for (int k = 0; k < 8; k++) rb[k] = bytes_q[i][7-k];
      c = c ^ {rb, 24'd0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return r ^ 32'hFFFFFFFF;
  endfunction

  task automatic push_word(input word_t w);
    int n;
    n = w.eop ? int'(w.keep) + 1 : 4;
    for (int k = 0; k < n; k++) bytes_q.push_back(w.d[8*k +: 8]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit src, input logic v, input word_t w);
    if (src) begin
      s1_valid = v; s1_data = w.d; s1_sop = w.sop; s1_eop = w.eop; s1_keep = w.keep;
    end else begin
      s0_valid = v; s0_data = w.d; s0_sop = w.sop; s0_eop = w.eop; s0_keep = w.keep;
    end
  endtask

  task automatic wait_ready(input bit src, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if ((src ? s1_ready : s0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("ready_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic get_result(input logic [31:0] ecrc, input bit esrc, input logic eerr);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (crc_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("crc_valid_timeout", {31'd0, ok}, 32'd1);
    if (!ok) return;
    chk("crc_out", crc_out, ecrc);
    chk("crc_src", {31'd0, crc_src}, {31'd0, esrc});
    chk("crc_err", {31'd0, crc_err}, {31'd0, eerr});
    last_crc = crc_out;
    crc_ready = 1'b1;
    @(posedge clk); #1;
    crc_ready = 1'b0;
    chk("crc_valid_clear", {31'd0, crc_valid}, 32'd0);
  endtask

  // Sends frame_q on one source and computes the expected result from the byte stream.
  task automatic send_words(input bit src, input bit gaps);
    bit ok;
    bytes_q.delete();
    exp_err = 1'b0;
    foreach (frame_q[i]) begin
      if (i > 0 && frame_q[i].sop) begin
        bytes_q.delete();
        exp_err = 1'b1;
      end
      push_word(frame_q[i]);
    end
    exp_crc = ref_crc();
    foreach (frame_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        drive(src, 1'b0, frame_q[i]);
        @(posedge clk); #1;
      end
      drive(src, 1'b1, frame_q[i]);
      wait_ready(src, ok);
      if (!ok) begin
        drive(src, 1'b0, frame_q[i]);
        return;
      end
      if (frame_q[i].eop) chk("pre_eop_valid", {31'd0, crc_valid}, 32'd0);
      @(posedge clk); #1;
    end
    drive(src, 1'b0, mk(0, 0, 0, 0));
    chk("eop_latency", {31'd0, crc_valid}, 32'd1);
  endtask

  task automatic send_frame(input bit src, input bit gaps);
    send_words(src, gaps);
    get_result(exp_crc, src, exp_err);
  endtask

  initial begin
    bit    ok, who;
    word_t w0, w1;
    int    len;
    rst_n = 1'b0; crc_ready = 1'b0;
    drive(0, 1'b1, mk(32'h1234, 0, 0, 0));
    drive(1, 1'b0, mk(0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
    chk("rst_s1_ready", {31'd0, s1_ready}, 32'd0);
    chk("rst_crc_valid", {31'd0, crc_valid}, 32'd0);
    chk("rst_crc_out", crc_out, 32'd0);
    chk("rst_crc_src", {31'd0, crc_src}, 32'd0);
    chk("rst_crc_err", {31'd0, crc_err}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    drive(0, 1'b0, mk(0, 0, 0, 0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    frame_q = '{mk(32'h34333231, 1, 0, 0), mk(32'h38373635, 0, 0, 0), mk(32'h00000039, 0, 1, 0)};
    send_frame(0, 0);
    chk("check_123456789", last_crc, 32'hCBF43926);

    frame_q = '{mk(32'h0, 1, 1, 0)};
    send_frame(1, 0);
    chk("single_zero_byte", last_crc, 32'hD202EF8D);

    w0 = mk($urandom, 1, 1, 2'($urandom_range(0, 3)));
    w1 = mk($urandom, 1, 1, 2'($urandom_range(0, 3)));
    drive(0, 1'b1, w0);
    drive(1, 1'b1, w1);
    for (int f = 0; f < 4; f++) begin
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (s0_ready === 1'b1 || s1_ready === 1'b1) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      chk("arb_timeout", {31'd0, ok}, 32'd1);
      if (!ok) break;
      who = s1_ready;
      chk("arb_order", {31'd0, who}, 32'(f % 2));
      bytes_q.delete();
      push_word(who ? w1 : w0);
      exp_crc = ref_crc();
      @(posedge clk); #1;
      if (f == 3) begin
        drive(0, 1'b0, w0);
        drive(1, 1'b0, w1);
      end else if (who) begin
        w1 = mk($urandom, 1, 1, 2'($urandom_range(0, 3)));
        drive(1, 1'b1, w1);
      end else begin
        w0 = mk($urandom, 1, 1, 2'($urandom_range(0, 3)));
        drive(0, 1'b1, w0);
      end
      get_result(exp_crc, who, 1'b0);
    end
    drive(0, 1'b0, w0);
    drive(1, 1'b0, w1);

    frame_q = '{mk($urandom, 1, 0, 3), mk($urandom, 0, 1, 2)};
    send_words(0, 0);
    w1 = mk(32'h0, 1, 1, 0);
    drive(1, 1'b1, w1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, crc_valid}, 32'd1);
      chk("hold_crc_out", crc_out, exp_crc);
      chk("hold_s0_ready", {31'd0, s0_ready}, 32'd0);
      chk("hold_s1_ready", {31'd0, s1_ready}, 32'd0);
      @(posedge clk); #1;
    end
    get_result(exp_crc, 1'b0, 1'b0);
    wait_ready(1, ok);
    @(posedge clk); #1;
    drive(1, 1'b0, w1);
    get_result(32'hD202EF8D, 1'b1, 1'b0);

    frame_q = '{mk(32'hDEADBEEF, 1, 0, 3), mk(32'h34333231, 1, 0, 0),
                mk(32'h38373635, 0, 0, 0), mk(32'h00000039, 0, 1, 0)};
    send_frame(0, 0);
    chk("restart_crc", last_crc, 32'hCBF43926);

    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 5);
      frame_q.delete();
      for (int i = 0; i < len; i++)
        frame_q.push_back(mk($urandom, (i == 0) || ($urandom_range(0, 7) == 0),
                             i == len - 1, 2'($urandom_range(0, 3))));
      send_frame(1'($urandom_range(0, 1)), 1);
    end

    drive(1, 1'b1, mk($urandom, 0, 0, 0));
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("orphan_ready", {31'd0, s1_ready}, 32'd1);
      @(posedge clk); #1;
      drive(1, 1'b1, mk($urandom, 0, 0, 0));
    end
    drive(1, 1'b0, mk(0, 0, 0, 0));
    @(negedge clk);
    chk("drop_cnt_3", {16'd0, drop_cnt}, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b1, mk($urandom, 1, 0, 0));
    wait_ready(0, ok);
    @(posedge clk); #1;
    drive(0, 1'b1, mk($urandom, 0, 0, 0));
    wait_ready(0, ok);
    @(posedge clk); #1;
    drive(0, 1'b1, mk($urandom, 0, 1, 0));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_s0_ready", {31'd0, s0_ready}, 32'd0);
    chk("midrst_crc_valid", {31'd0, crc_valid}, 32'd0);
    chk("midrst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    drive(0, 1'b0, mk(0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    w1 = mk($urandom, 1, 1, 1);
    drive(1, 1'b1, w1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_grant_yet", {31'd0, s1_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_grant", {31'd0, s1_ready}, 32'd1);
    chk("post_rst_no_valid", {31'd0, crc_valid}, 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, w1);
    chk("post_rst_latency", {31'd0, crc_valid}, 32'd1);
    bytes_q.delete();
    push_word(w1);
    get_result(ref_crc(), 1'b1, 1'b0);

    drive(0, 1'b1, mk($urandom, 0, 0, 0));
    drive(1, 1'b1, mk($urandom, 0, 1, 2));
    @(negedge clk);
    chk("dual_drop_s0_ready", {31'd0, s0_ready}, 32'd1);
    chk("dual_drop_s1_ready", {31'd0, s1_ready}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, mk(0, 0, 0, 0));
    drive(1, 1'b0, mk(0, 0, 0, 0));
    @(negedge clk);
    chk("dual_drop_cnt", {16'd0, drop_cnt}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crc32_frame_arb.md
CRC32_FRAME_ARB -- requirements
Module: crc32_frame_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- INIT, 32'hFFFFFFFF, CRC register seed at frame start
- XOR_OUT, 32'hFFFFFFFF, final XOR applied to the result
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge
- rst_n, in, 1, asynchronous active-low reset
- s0_data / s1_data, in, 32, source word; byte0 = data[7:0] is sent first
- s0_valid / s1_valid, in, 1, word valid
- s0_sop / s1_sop, in, 1, first word of frame
- s0_eop / s1_eop, in, 1, last word of frame
- s0_keep / s1_keep, in, 2, valid bytes on eop word minus 1; ignored when eop=0
- s0_ready / s1_ready, out, 1, word accepted when valid&ready
- crc_valid, out, 1, result available
- crc_ready, in, 1, result consumed when crc_valid&crc_ready
- crc_out, out, 32, CRC-32/ISO-HDLC of the frame
- crc_src, out, 1, source index of the result
- crc_err, out, 1, frame contained a mid-frame sop (restart)
- drop_cnt, out, 16, saturating count of discarded orphan words

Function
REQ-003 The CRC SHALL use polynomial 0x04C11DB7, reflected input bits, seed INIT, reflected output and final XOR XOR_OUT, so that the ASCII string "123456789" yields 32'hCBF43926.
REQ-004 Per accepted word, the engine SHALL fold 1 to 4 bytes in a single cycle in order byte0..byte3. Non-eop words SHALL fold 4 bytes; eop words SHALL fold keep+1 bytes.
REQ-005 The FSM SHALL have exactly three states: IDLE, BUSY and RESULT.
REQ-006 IDLE, request handling:
- a request is valid&sop on a source
- if both sources request, grant the source named by rr_ptr; otherwise grant the single requester
- the grant is registered, and the state moves to BUSY on the next cycle
REQ-007 IDLE, orphan words: a source presenting valid&!sop SHALL get ready=1, its word SHALL be discarded, and drop_cnt SHALL increment (saturating at 16'hFFFF; both sources may drop in one cycle, adding 2).
REQ-008 BUSY, word acceptance:
- only the granted source's ready SHALL be 1
- the non-granted source's ready SHALL be 0
- the first accepted word SHALL load the CRC from INIT
REQ-009 BUSY, mid-frame sop: an accepted word with sop after the first word SHALL restart the CRC from INIT with that word and SHALL set the sticky crc_err flag for the frame.
REQ-010 BUSY, end of frame: an accepted word with eop SHALL move the state to RESULT. crc_valid SHALL rise on the cycle after that acceptance; latency from eop acceptance to crc_valid is 1 clock.
REQ-011 A word carrying both sop and eop SHALL form a complete one-word frame.
REQ-012 RESULT:
- crc_out, crc_src and crc_err SHALL be held stable while crc_valid=1
- both ready outputs SHALL be 0
- on crc_valid&crc_ready: go to IDLE, clear crc_valid, set rr_ptr to the other source than crc_src
REQ-013 Throughput SHALL be one word per clock in BUSY. Frame-to-frame overhead SHALL be at least 2 idle clocks (the RESULT handshake and the IDLE grant).
REQ-014 A source dropping valid mid-frame SHALL simply stall BUSY; there SHALL be no timeout.

Reset
REQ-015 While rst_n=0, the block SHALL hold the following, asynchronously:
- state=IDLE, rr_ptr=0
- s0_ready=0, s1_ready=0, crc_valid=0
- crc_out=0, crc_src=0, crc_err=0, drop_cnt=0
- internal CRC register=INIT
REQ-016 Reset asserted mid-frame SHALL discard the frame; no partial result SHALL be produced after release.
REQ-017 The first IDLE cycle after rst_n rises SHALL already grant requests.

Structure
REQ-018 The shared package crc32_pkg SHALL hold:
- the polynomial, INIT and XOR_OUT defaults
- the FSM state typedef
- the combinational byte-step function crc32_d8(data[7:0], crc[31:0])
REQ-019 One sub-module, crc32_word_step, SHALL be used: combinational, 4 chained crc32_d8 stages, with a byte-count select. All registers SHALL stay in crc32_frame_arb.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- s0 sends 32'h34333231, 32'h38373635, then 32'h00000039 with eop and keep=0 -> crc_valid one clock after the eop acceptance, crc_out=32'hCBF43926, crc_src=0, crc_err=0.
- s1 sends a single word with sop=eop=1, data=0 and keep=0 -> crc_out=32'hD202EF8D, crc_src=1.
- s0 and s1 both request in the same IDLE cycle, repeated for 4 frames -> grants in order s0, s1, s0, s1.
- crc_ready held at 0 for 10 clocks -> crc_valid, crc_out and both ready outputs stay constant; the state returns to IDLE only on the handshake.
- Mid-frame sop on s0 carrying "1234" followed by "56789" -> crc_out=CRC of "123456789" (32'hCBF43926) with crc_err=1.
- 3 orphan words on s1 in IDLE, then rst_n pulsed low mid-frame -> drop_cnt=3 before the reset and 0 after; no crc_valid after release.
